// File: rtl/ofifo_multi_if.sv
// Handshake/data bundle between the MAC-array writer side and the SFU reader side of ofifo_multi.
// o_out_valid exists only when OFIFO_OREG_EN is defined.
interface ofifo_multi_if #(
    parameter int col   = 8,
    parameter int bw    = 12,
    parameter int depth = 64
);
    localparam int aw = $clog2(depth);

    logic [col*bw-1:0] in;
    logic [col-1:0]    wr;
    logic [col-1:0]    col_en;
    logic              rd;
    logic              clr_flags;
    logic [col*bw-1:0] out;
    logic              o_valid;
    logic              o_ready;
    logic [col-1:0]    o_full;
    logic [aw:0]       o_count;
    logic              o_overflow;
    logic              o_underflow;
`ifdef OFIFO_OREG_EN
    logic              o_out_valid;
`endif

    modport master (
        output in, wr, col_en, rd, clr_flags,
        input  out, o_valid, o_ready, o_full, o_count, o_overflow, o_underflow
`ifdef OFIFO_OREG_EN
        , input o_out_valid
`endif
    );

    modport slave (
        input  in, wr, col_en, rd, clr_flags,
        output out, o_valid, o_ready, o_full, o_count, o_overflow, o_underflow
`ifdef OFIFO_OREG_EN
        , output o_out_valid
`endif
    );
endinterface

// File: rtl/ofifo_multi.sv
// Bank of per-column circular buffers; a row pops only when every enabled column holds data.
// Define OFIFO_OREG_EN to register the popped row on out and add the o_out_valid pulse.
module ofifo_multi #(
    parameter int col   = 8,
    parameter int bw    = 12,
    parameter int depth = 64
) (
    input  logic          clk,
    input  logic          reset,
    ofifo_multi_if.slave  bus
);
    localparam int aw = $clog2(depth);
    localparam logic [aw:0] full_cnt = (aw+1)'(depth);

    logic [col-1:0]          full_v;
    logic [col-1:0]          nonempty_v;
    logic [col-1:0][aw:0]    cnt_v;
    logic [col*bw-1:0]       head_row;
    logic                    valid;
    logic                    pop;
    logic [aw:0]             min_cnt;

    assign valid = (|bus.col_en) && (&(nonempty_v | ~bus.col_en));
    assign pop   = bus.rd && valid;

    genvar gi;
    generate
        for (gi = 0; gi < col; gi++) begin : g_col
            logic [bw-1:0] mem_q [depth];
            logic [aw-1:0] wptr_q, wptr_d, rptr_q, rptr_d;
            logic [aw:0]   cnt_q, cnt_d;
            logic          wr_acc, pop_c;

            // A full column still accepts a write when the same edge pops it.
            assign wr_acc = bus.wr[gi] && bus.col_en[gi] && (!full_v[gi] || pop);
            assign pop_c  = pop && bus.col_en[gi];

            always_comb begin
                wptr_d = wptr_q;
                rptr_d = rptr_q;
                cnt_d  = cnt_q;
                if (wr_acc) wptr_d = wptr_q + 1'b1;
                if (pop_c)  rptr_d = rptr_q + 1'b1;
                case ({wr_acc, pop_c})
                    2'b10:   cnt_d = cnt_q + 1'b1;
                    2'b01:   cnt_d = cnt_q - 1'b1;
                    default: cnt_d = cnt_q;
                endcase
            end

            always_ff @(posedge clk or negedge reset) begin
                if (!reset) begin
                    wptr_q <= '0;
                    rptr_q <= '0;
                    cnt_q  <= '0;
                end else begin
                    wptr_q <= wptr_d;
                    rptr_q <= rptr_d;
                    cnt_q  <= cnt_d;
                end
            end

            always_ff @(posedge clk) begin
                if (wr_acc) mem_q[wptr_q] <= bus.in[gi*bw +: bw];
            end

            assign full_v[gi]     = (cnt_q == full_cnt);
            assign nonempty_v[gi] = (cnt_q != '0);
            assign cnt_v[gi]      = cnt_q;
            assign head_row[gi*bw +: bw] = bus.col_en[gi] ? mem_q[rptr_q] : '0;
        end
    endgenerate

    always_comb begin
        min_cnt = full_cnt;
        for (int i = 0; i < col; i++) begin
            if (bus.col_en[i] && (cnt_v[i] < min_cnt)) min_cnt = cnt_v[i];
        end
    end

    assign bus.o_valid = valid;
    assign bus.o_ready = &(~full_v | ~bus.col_en);
    assign bus.o_full  = full_v;
    assign bus.o_count = (|bus.col_en) ? min_cnt : '0;

    // Sticky error flags; a set event in the same cycle overrides clr_flags.
    logic ovf_set, unf_set;
    logic ovf_q, ovf_d, unf_q, unf_d;

    assign ovf_set = (|(bus.wr & bus.col_en & full_v)) && !pop;
    assign unf_set = bus.rd && !valid;

    always_comb begin
        ovf_d = ovf_q;
        unf_d = unf_q;
        if (ovf_set)            ovf_d = 1'b1;
        else if (bus.clr_flags) ovf_d = 1'b0;
        if (unf_set)            unf_d = 1'b1;
        else if (bus.clr_flags) unf_d = 1'b0;
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            ovf_q <= 1'b0;
            unf_q <= 1'b0;
        end else begin
            ovf_q <= ovf_d;
            unf_q <= unf_d;
        end
    end

    assign bus.o_overflow  = ovf_q;
    assign bus.o_underflow = unf_q;

`ifdef OFIFO_OREG_EN
    logic [col*bw-1:0] out_q;
    logic              out_valid_q;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            out_q       <= '0;
            out_valid_q <= 1'b0;
        end else begin
            if (pop) out_q <= head_row;
            out_valid_q <= pop;
        end
    end

    assign bus.out         = out_q;
    assign bus.o_out_valid = out_valid_q;
`else
    assign bus.out = head_row;
`endif
endmodule

// File: tb/tb_ofifo_multi.sv
// Self-checking bench for ofifo_multi: queue-based reference model, per-cycle compare, directed + random stimulus.
module tb_ofifo_multi;
    localparam int COL   = 8;
    localparam int BW    = 12;
    localparam int DEPTH = 4;
    localparam int AW    = 2;

    logic clk   = 1'b0;
    logic reset = 1'b0;
    always #5 clk = ~clk;

    ofifo_multi_if #(.col(COL), .bw(BW), .depth(DEPTH)) bus ();

    ofifo_multi #(.col(COL), .bw(BW), .depth(DEPTH)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    int n_vec = 0;
    int n_err = 0;

    task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s at %0t: got %h, expected %h", name, $time, act, exp);
        end
    endtask

    // ---------------- reference model ----------------
    logic [BW-1:0] mq [COL][$];
    bit m_ovf = 0;
    bit m_unf = 0;
`ifdef OFIFO_OREG_EN
    logic [COL*BW-1:0] m_oreg = '0;
    bit m_ovalid = 0;
`endif

    function automatic bit m_valid();
        bit any = 0;
        for (int i = 0; i < COL; i++) begin
            if (bus.col_en[i]) begin
                any = 1;
                if (mq[i].size() == 0) return 0;
            end
        end
        return any;
    endfunction

    function automatic int m_count();
        int m = DEPTH;
        if (bus.col_en == 0) return 0;
        for (int i = 0; i < COL; i++)
            if (bus.col_en[i] && mq[i].size() < m) m = mq[i].size();
        return m;
    endfunction

    function automatic logic [COL-1:0] m_full();
        logic [COL-1:0] f = '0;
        for (int i = 0; i < COL; i++) f[i] = (mq[i].size() == DEPTH);
        return f;
    endfunction

    function automatic bit m_ready();
        for (int i = 0; i < COL; i++)
            if (bus.col_en[i] && mq[i].size() == DEPTH) return 0;
        return 1;
    endfunction

    function automatic logic [COL*BW-1:0] m_head();
        logic [COL*BW-1:0] h = '0;
        for (int i = 0; i < COL; i++)
            if (bus.col_en[i] && mq[i].size() != 0) h[i*BW +: BW] = mq[i][0];
        return h;
    endfunction

    always @(posedge clk or negedge reset) begin
        if (!reset) begin
            for (int i = 0; i < COL; i++) mq[i].delete();
            m_ovf = 0;
            m_unf = 0;
`ifdef OFIFO_OREG_EN
            m_oreg   = '0;
            m_ovalid = 0;
`endif
        end else begin
            bit pop_e, ovf_e, unf_e;
            pop_e = bus.rd && m_valid();
            unf_e = bus.rd && !pop_e;
            ovf_e = 0;
`ifdef OFIFO_OREG_EN
            if (pop_e) m_oreg = m_head();
            m_ovalid = pop_e;
`endif
            if (pop_e)
                for (int i = 0; i < COL; i++)
                    if (bus.col_en[i]) void'(mq[i].pop_front());
            for (int i = 0; i < COL; i++) begin
                if (bus.wr[i] && bus.col_en[i]) begin
                    if (mq[i].size() < DEPTH) mq[i].push_back(bus.in[i*BW +: BW]);
                    else ovf_e = 1;
                end
            end
            if (ovf_e) m_ovf = 1; else if (bus.clr_flags) m_ovf = 0;
            if (unf_e) m_unf = 1; else if (bus.clr_flags) m_unf = 0;
        end
    end

    // ---------------- per-cycle compare ----------------
    always @(negedge clk) begin
        if (reset) begin
            chk("o_valid",     {127'b0, bus.o_valid},     {127'b0, m_valid()});
            chk("o_ready",     {127'b0, bus.o_ready},     {127'b0, m_ready()});
            chk("o_full",      128'(bus.o_full),          128'(m_full()));
            chk("o_count",     128'(bus.o_count),         128'(m_count()));
            chk("o_overflow",  {127'b0, bus.o_overflow},  {127'b0, m_ovf});
            chk("o_underflow", {127'b0, bus.o_underflow}, {127'b0, m_unf});
`ifdef OFIFO_OREG_EN
            chk("out_reg",     128'(bus.out),             128'(m_oreg));
            chk("o_out_valid", {127'b0, bus.o_out_valid}, {127'b0, m_ovalid});
`else
            if (m_valid()) chk("out_head", 128'(bus.out), 128'(m_head()));
`endif
        end
    end

    // ---------------- stimulus ----------------
    function automatic logic [COL*BW-1:0] row(input int base);
        logic [COL*BW-1:0] r;
        for (int i = 0; i < COL; i++) r[i*BW +: BW] = BW'(base + i);
        return r;
    endfunction

    task automatic step(input logic [COL-1:0] w, input logic [COL*BW-1:0] d,
                        input logic r, input logic c);
        bus.wr = w; bus.in = d; bus.rd = r; bus.clr_flags = c;
        @(posedge clk); #1;
        bus.wr = '0; bus.rd = 1'b0; bus.clr_flags = 1'b0;
    endtask

    initial begin
        bus.in = '0; bus.wr = '0; bus.col_en = 8'hFF; bus.rd = 1'b0; bus.clr_flags = 1'b0;
        reset = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        chk("rst_valid", 128'(bus.o_valid), 128'd0);
        chk("rst_count", 128'(bus.o_count), 128'd0);
        chk("rst_ready", 128'(bus.o_ready), 128'd1);
        chk("rst_full",  128'(bus.o_full),  128'd0);
        chk("rst_ovf",   128'(bus.o_overflow),  128'd0);
        chk("rst_unf",   128'(bus.o_underflow), 128'd0);
        #2 reset = 1'b1;
        @(posedge clk); #1;

        // 1: staggered column writes
        for (int i = 0; i < COL; i++) begin
            step(COL'(1 << i), row('h10), 1'b0, 1'b0);
            if (i < COL - 1) chk("t1_valid_low", 128'(bus.o_valid), 128'd0);
        end
        chk("t1_valid", 128'(bus.o_valid), 128'd1);
        chk("t1_count", 128'(bus.o_count), 128'd1);
`ifndef OFIFO_OREG_EN
        chk("t1_out", 128'(bus.out), 128'h017016015014013012011010);
`endif
        step('0, '0, 1'b1, 1'b0);
        $display("test1 staggered writes: count=%0d", bus.o_count);

        // 2: fill and overflow
        for (int r = 0; r < DEPTH; r++) step(8'hFF, row(r * 'h100), 1'b0, 1'b0);
        step(8'hFF, row('h500), 1'b0, 1'b0);
        chk("t2_full",  128'(bus.o_full),     128'hFF);
        chk("t2_ready", 128'(bus.o_ready),    128'd0);
        chk("t2_ovf",   128'(bus.o_overflow), 128'd1);
        chk("t2_count", 128'(bus.o_count),   128'd4);
`ifndef OFIFO_OREG_EN
        chk("t2_out", 128'(bus.out), 128'h007006005004003002001000);
`endif
        step('0, '0, 1'b0, 1'b1);
        chk("t2_clr", 128'(bus.o_overflow), 128'd0);
        $display("test2 fill/overflow: full=%h", bus.o_full);

        // 3: write + pop on a full FIFO
        step(8'hFF, row('h400), 1'b1, 1'b0);
        chk("t3_count", 128'(bus.o_count),   128'd4);
        chk("t3_ovf",   128'(bus.o_overflow), 128'd0);
`ifndef OFIFO_OREG_EN
        chk("t3_out", 128'(bus.out), 128'h107106105104103102101100);
`endif
        for (int r = 1; r <= DEPTH; r++) begin
`ifndef OFIFO_OREG_EN
            chk("t3_drain", 128'(bus.out), 128'(row(r * 'h100)));
`endif
            step('0, '0, 1'b1, 1'b0);
        end
        chk("t3_empty", 128'(bus.o_count), 128'd0);
        $display("test3 write+pop on full: drained");

        // 4: underflow and clr_flags priority
        step('0, '0, 1'b1, 1'b0);
        chk("t4_unf",   128'(bus.o_underflow), 128'd1);
        chk("t4_count", 128'(bus.o_count),     128'd0);
        step('0, '0, 1'b0, 1'b1);
        chk("t4_clr", 128'(bus.o_underflow), 128'd0);
        step('0, '0, 1'b1, 1'b0);
        step('0, '0, 1'b1, 1'b1);
        chk("t4_set_wins", 128'(bus.o_underflow), 128'd1);
        step('0, '0, 1'b0, 1'b1);
        $display("test4 underflow: unf=%0d", bus.o_underflow);

        // 5: partial column enable
        bus.col_en = 8'h0F;
        @(posedge clk); #1;
        for (int r = 0; r < 3; r++) step(8'hFF, row('h20 + r * 'h10), 1'b0, 1'b0);
        for (int r = 0; r < 5; r++) step(8'hF0, row('h300), 1'b0, 1'b0);
        chk("t5_valid", 128'(bus.o_valid),    128'd1);
        chk("t5_count", 128'(bus.o_count),    128'd3);
        chk("t5_ovf",   128'(bus.o_overflow), 128'd0);
`ifndef OFIFO_OREG_EN
        chk("t5_upper_zero", 128'(bus.out[COL*BW-1:COL*BW/2]), 128'd0);
`endif
        for (int r = 0; r < 3; r++) step('0, '0, 1'b1, 1'b0);
        bus.col_en = 8'hFF;
        @(posedge clk); #1;
        $display("test5 col_en=0x0F: done");

        // 6: pointer wrap, then async reset mid-stream
        for (int k = 0; k < 10; k++) begin
            step(8'hFF, row(k * 'h10 + 'h600), 1'b0, 1'b0);
`ifndef OFIFO_OREG_EN
            chk("t6_wrap", 128'(bus.out), 128'(row(k * 'h10 + 'h600)));
`endif
            step('0, '0, 1'b1, 1'b0);
        end
        step(8'hFF, row('h700), 1'b0, 1'b0);
        step(8'hFF, row('h710), 1'b0, 1'b0);
        #2 reset = 1'b0;
        #1;
        chk("t6_rst_valid", 128'(bus.o_valid), 128'd0);
        chk("t6_rst_count", 128'(bus.o_count), 128'd0);
        @(posedge clk); #3 reset = 1'b1;
        @(posedge clk); #1;
        chk("t6_post_valid", 128'(bus.o_valid), 128'd0);
        chk("t6_post_count", 128'(bus.o_count), 128'd0);
        chk("t6_post_ready", 128'(bus.o_ready), 128'd1);
        $display("test6 wrap + async reset: done");

        // random phase
        for (int n = 0; n < 3000; n++) begin
            if ($urandom_range(0, 49) == 0) begin
                bus.col_en = ($urandom_range(0, 9) == 0) ? 8'h00 : 8'($urandom);
                @(posedge clk); #1;
            end else if ($urandom_range(0, 299) == 0) begin
                #2 reset = 1'b0;
                #3 reset = 1'b1;
                @(posedge clk); #1;
            end else begin
                logic [COL*BW-1:0] d;
                for (int i = 0; i < COL; i++) d[i*BW +: BW] = BW'($urandom);
                step(($urandom_range(0, 3) == 0) ? 8'hFF : 8'($urandom), d,
                     1'($urandom_range(0, 99) < 40), 1'($urandom_range(0, 19) == 0));
            end
        end
        $display("random phase: 3000 cycles");

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule

// File: doc/ofifo_multi.md
Name: ofifo_multi

Overview:
Parametrised successor to the core's output FIFO. It is a bank of `col` independent per-column circular buffers. Each column is written by its own `wr` strobe from the MAC array. A row is read out only when every enabled column has data, so the row arrives aligned at the SFU. Compared with the fixed ofifo it adds configurable depth, a runtime column-enable mask, per-column full flags, a ready-row count and sticky overflow/underflow error flags.

Parameters:
col, 8, number of columns/channels
bw, 12, bits per column entry (bw_psum)
depth, 64, entries per column; power of 2, >=2; aw = log2(depth) is a derived localparam

Ports:
clk  input  1  clock, rising edge
reset  input  1  asynchronous, active-low reset (0 = reset)
in  input  col*bw  write data; column i occupies [bw*(i+1)-1 : bw*i]
wr  input  col  per-column write strobe
col_en  input  col  column enable mask; change only while wr=0 and rd=0
rd  input  1  pop one aligned row
clr_flags  input  1  synchronous clear of the sticky error flags
out  output  col*bw  head row; disabled columns read as 0
o_valid  output  1  at least one column enabled and every enabled column non-empty
o_ready  output  1  every enabled column not full
o_full  output  col  per-column full
o_count  output  aw+1  minimum occupancy over enabled columns; 0 if none enabled
o_overflow  output  1  sticky: write attempted on a full column
o_underflow  output  1  sticky: rd asserted while o_valid=0

Behaviour:
- Storage: each column has its own circular buffer with wptr[aw-1:0], rptr[aw-1:0] and cnt[aw:0]. Pointers wrap from depth-1 to 0. full = (cnt==depth); empty = (cnt==0).
- Write accept, column i: wr[i] && col_en[i] && (!full[i] || pop).
  - On accept: mem[wptr] <= data, wptr++, cnt++.
  - Write to a disabled column: ignored; no flag is raised.
- Pop: pop = rd && o_valid. On pop, every enabled column does rptr++ and cnt--.
- Simultaneous write and pop on the same column: both take effect and cnt is unchanged. This is allowed even when the column is full; the write is accepted and is not an overflow.
- Overflow: wr[i] && col_en[i] && full[i] && !pop sets o_overflow. The data is dropped.
- Underflow: rd && !o_valid sets o_underflow. No state changes.
- clr_flags: clears both sticky flags at the next edge. If a set event occurs in the same cycle, the set wins.
- Default (no macro), show-ahead output: out is combinational from the head entry of each enabled column. It is valid whenever o_valid=1 and updates in the cycle after a pop.
- o_valid, o_ready, o_full and o_count are combinational from the counters and col_en. They reflect writes and pops one cycle after the accepting edge.
- Latency: data written at edge N is visible on out/o_valid after edge N, provided all other enabled columns are non-empty.
- Reset (reset=0, asynchronous, any time including mid-operation):
  - Pointers, counters and flags go to 0, so o_valid=0, o_count=0, o_overflow=0, o_underflow=0.
  - o_full=0 and o_ready=1 (if any column is enabled; o_ready=1 when none is enabled).
  - Memory contents are not cleared; all queued data is discarded.
- col_en=0 (all columns disabled): o_valid=0, o_count=0, out=0, and rd sets underflow.

Optional Feature:
OFIFO_OREG_EN
- Defined: out is a register.
  - On pop, out <= the popped head row (disabled columns 0); otherwise it holds.
  - It resets to 0.
  - Row data appears one cycle after the rd edge.
  - An extra output o_out_valid is added: 1-cycle pulse the cycle after each pop, reset 0.
- Undefined: show-ahead combinational out as described above; o_out_valid is absent.

Test Plan:
1. depth=4, col_en=0xFF: write columns 0..7 in staggered cycles with value 0x10+i. o_valid must rise only after the column 7 write; out = {0x17..0x10}; o_count=1.
2. depth=4, all columns enabled: 4 rows of writes, then a 5th wr=0xFF with rd=0. o_full=0xFF, o_ready=0, o_overflow=1, and the 4 rows pop back intact in order.
3. Full FIFO with wr=0xFF and rd=1 in the same cycle: row 0 pops, new data is accepted, o_count stays 4, and o_overflow stays 0.
4. rd=1 on an empty FIFO: o_underflow=1 and o_count stays 0. Then clr_flags=1 for 1 cycle clears it; clr_flags coincident with another rd keeps it set.
5. col_en=0x0F with 3 writes each to columns 0-3 and wr to columns 4-7: o_valid=1, o_count=3, out[upper 4 columns]=0, and no overflow from the ignored columns.
6. Pointer wrap and reset: depth=4, 10 write/pop pairs, data order preserved across the wrap. Then assert reset=0 mid-stream asynchronously (between edges): o_valid=0 and o_count=0 immediately, and after release the FIFO is empty.
